// File: rtl/de_pipe_stage.sv
// de_pipe_stage: Decode->Execute pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush to a control bubble and a saturating back-pressure counter.
module de_pipe_stage #(
  parameter int                DATA_W      = 16,
  parameter int                NUM_SRC     = 2,
  parameter int                CTRL_W      = 16,
  parameter int                DEST_W      = 4,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [NUM_SRC*DATA_W-1:0] in_src,
  input  logic [DEST_W-1:0]         in_dest,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [NUM_SRC*DATA_W-1:0] out_src,
  output logic [DEST_W-1:0]         out_dest,
  output logic [1:0]                occupancy,
  output logic [CNT_W-1:0]          stall_cnt
);
  localparam int SW = NUM_SRC * DATA_W;
  localparam int EW = CTRL_W + SW + DEST_W;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t            state_q, state_d;
  logic [EW-1:0]     main_q, main_d, skid_q, skid_d, in_e;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, consume;
  assign in_e      = {in_ctrl, in_src, in_dest};
  assign out_valid = state_q != EMPTY;
  assign in_ready  = state_q != FULL;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_q[EW-1 -: CTRL_W] : CTRL_BUBBLE;
  assign out_src   = main_q[DEST_W +: SW];
  assign out_dest  = main_q[DEST_W-1:0];
  assign occupancy = state_q;
  assign stall_cnt = cnt_q;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (accept) begin
        main_d  = in_e;
        state_d = ONE;
      end
      ONE: if (accept && consume) main_d = in_e;
      else if (accept) begin
        skid_d  = in_e;
        state_d = FULL;
      end else if (consume) state_d = EMPTY;
      FULL: if (consume) begin
        main_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    // flush discards everything, including the entry accepted this cycle
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    cnt_d = (out_valid && !out_ready && !(&cnt_q)) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
